// File: rtl/cost_table_loader.sv
// ---------------------------------------------------------------------------
// cost_table_loader
//
// Receives the 8x8 worker/job cost matrix as a 64-beat valid/ready stream
// (row-major, beat k = Cost(W=k/8, J=k%8)) and keeps it in a register file
// for the assignment search engine. It also builds a row-minimum lower bound
// on the total assignment cost while the matrix streams in.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST_N      asynchronous active-low reset
//   in_valid   upstream presents a cost beat
//   in_ready   block accepts a beat this cycle (decoded from state only)
//   in_data    cost beat
//   in_last    marks the final beat of the matrix
//   clear      synchronous restart of loading; wins over a concurrent beat
//   W, J       engine worker / job lookup indices
//   Cost       table[{W,J}], combinational read
//   Ready_tbl  registered: table complete and framed correctly
//   LowerBound registered: sum of row minima, valid while Ready_tbl=1
//   Error      registered: framing error seen
// ---------------------------------------------------------------------------
module cost_table_loader #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int LBW = 10
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CW-1:0]  in_data,
  input  logic           in_last,
  input  logic           clear,
  input  logic [2:0]     W,
  input  logic [2:0]     J,
  output logic [CW-1:0]  Cost,
  output logic           Ready_tbl,
  output logic [LBW-1:0] LowerBound,
  output logic           Error
);

  localparam int DEPTH = N * N;
  localparam int IW    = $clog2(DEPTH);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_DONE  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  logic [1:0]     state_reg,  state_next;
  logic [IW-1:0]  idx_reg,    idx_next;
  logic [CW-1:0]  rowmin_reg, rowmin_next;
  logic [LBW-1:0] lb_acc_reg, lb_acc_next;
  logic [LBW-1:0] lb_out_reg, lb_out_next;
  logic           ready_reg,  ready_next;
  logic           error_reg,  error_next;

  logic [CW-1:0]  table_reg [DEPTH];

  logic           accept;
  logic           wr_en;
  logic           row_start;
  logic           row_end;
  logic           final_idx;
  logic [CW-1:0]  beat_min;

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready  = (state_reg == ST_LOAD);
  assign accept    = in_valid & in_ready;
  // clear drops a beat that handshakes on the same edge.
  assign wr_en     = accept & ~clear;

  assign row_start = (idx_reg[2:0] == 3'd0);
  assign row_end   = (idx_reg[2:0] == 3'd7);
  assign final_idx = (idx_reg == IW'(DEPTH - 1));
  // On the first beat of a row the running minimum restarts from the beat.
  assign beat_min  = (row_start || (in_data < rowmin_reg)) ? in_data : rowmin_reg;

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    rowmin_next = rowmin_reg;
    lb_acc_next = lb_acc_reg;
    lb_out_next = lb_out_reg;
    ready_next  = ready_reg;
    error_next  = error_reg;

    if (clear) begin
      state_next  = ST_LOAD;
      idx_next    = '0;
      rowmin_next = '0;
      lb_acc_next = '0;
      lb_out_next = '0;
      ready_next  = 1'b0;
      error_next  = 1'b0;
    end else if (accept) begin
      idx_next    = idx_reg + 1'b1;
      rowmin_next = beat_min;
      if (row_end) begin
        lb_acc_next = lb_acc_reg + {{(LBW-CW){1'b0}}, beat_min};
      end
      // Beat 63 always leaves LOAD, so idx can never wrap while loading.
      if (final_idx && in_last) begin
        state_next  = ST_DONE;
        ready_next  = 1'b1;
        lb_out_next = lb_acc_next;
      end else if (final_idx || in_last) begin
        state_next = ST_ERROR;
        error_next = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= ST_LOAD;
      idx_reg    <= '0;
      rowmin_reg <= '0;
      lb_acc_reg <= '0;
      lb_out_reg <= '0;
      ready_reg  <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      rowmin_reg <= rowmin_next;
      lb_acc_reg <= lb_acc_next;
      lb_out_reg <= lb_out_next;
      ready_reg  <= ready_next;
      error_reg  <= error_next;
    end
  end

  // One register per entry so reset can clear the whole table at once.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          table_reg[gi] <= '0;
        end else if (wr_en && (idx_reg == IW'(gi))) begin
          table_reg[gi] <= in_data;
        end
      end
    end
  endgenerate

  assign Cost       = table_reg[{W, J}];
  assign Ready_tbl  = ready_reg;
  assign Error      = error_reg;
  assign LowerBound = lb_out_reg;

endmodule

// File: tb/tb_cost_table_loader.sv
// ---------------------------------------------------------------------------
// tb_cost_table_loader
//
// Streams cost matrices into cost_table_loader and checks handshake, table
// readback, framing results and the row-minimum lower bound. The end-of-load
// outcome is pushed into a scoreboard when the terminating beat is driven and
// popped when Ready_tbl or Error shows up.
// ---------------------------------------------------------------------------
module tb_cost_table_loader;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic       in_last;
  logic       clear;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       Ready_tbl;
  logic [9:0] LowerBound;
  logic       Error;

  cost_table_loader dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .clear     (clear),
    .W         (W),
    .J         (J),
    .Cost      (Cost),
    .Ready_tbl (Ready_tbl),
    .LowerBound(LowerBound),
    .Error     (Error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rdy;
    logic       err;
    logic [9:0] lb;
  } exp_t;

  exp_t sb[$];

  int         vectors    = 0;
  int         miscompares = 0;

  // Bench-side view of what the table should hold and whether loading is open.
  logic [6:0] exp_tbl [64];
  logic       m_loading;
  int         m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sum of row minima taken straight from the expected table contents.
  function automatic logic [9:0] exp_lb();
    int s = 0;
    for (int r = 0; r < 8; r++) begin
      int mn = 127;
      for (int c = 0; c < 8; c++) begin
        if (int'(exp_tbl[r*8+c]) < mn) mn = int'(exp_tbl[r*8+c]);
      end
      s += mn;
    end
    return 10'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) exp_tbl[i] = '0;
    m_loading = 1'b1;
    m_cnt     = 0;
  endtask

  task automatic check_output();
    int   n = 0;
    exp_t e;
    while (!(Ready_tbl || Error) && n < 8) begin
      @(posedge CLK); #1;
      n++;
    end
    check_val("out_seen", 32'(Ready_tbl | Error), 1);
    e = sb.pop_front();
    check_val("ready_tbl", 32'(Ready_tbl), 32'(e.rdy));
    check_val("error", 32'(Error), 32'(e.err));
    if (e.rdy) check_val("lower_bound", 32'(LowerBound), 32'(e.lb));
    check_val("in_ready_end", 32'(in_ready), 0);
    $display("load end: ready=%0d error=%0d lb=%0d", Ready_tbl, Error, LowerBound);
  endtask

  task automatic drive_beat(input logic [6:0] d, input logic lst, input logic clr);
    int   widx;
    logic ended;
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = lst;
    clear    = clr;
    #1 check_val("in_ready", 32'(in_ready), 32'(m_loading));
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
    widx     = m_cnt;
    if (clr) begin
      m_loading = 1'b1;
      m_cnt     = 0;
    end else if (m_loading) begin
      exp_tbl[widx] = d;
      ended = (widx == 63) || lst;
      if (ended) begin
        exp_t e;
        m_loading = 1'b0;
        e.rdy = (widx == 63) && lst;
        e.err = !e.rdy;
        e.lb  = exp_lb();
        sb.push_back(e);
      end else begin
        m_cnt++;
      end
    end
    {W, J} = 6'(widx);
    #1 check_val("cost_rd", 32'(Cost), 32'(exp_tbl[widx]));
    if (sb.size() != 0) check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  task automatic clear_pulse();
    @(negedge CLK);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge CLK); #1;
    clear     = 1'b0;
    m_loading = 1'b1;
    m_cnt     = 0;
    check_val("clr_ready", 32'(Ready_tbl), 0);
    check_val("clr_error", 32'(Error), 0);
    check_val("clr_in_ready", 32'(in_ready), 1);
    $display("clear pulse");
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_in_ready"}, 32'(in_ready), 1);
    check_val({tag, "_ready"}, 32'(Ready_tbl), 0);
    check_val({tag, "_error"}, 32'(Error), 0);
    check_val({tag, "_lb"}, 32'(LowerBound), 0);
    for (int k = 0; k < 64; k++) begin
      {W, J} = 6'(k);
      #1 check_val({tag, "_cost"}, 32'(Cost), 0);
    end
    $display("%s state checked", tag);
  endtask

  initial begin
    RST_N    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    clear    = 1'b0;
    W        = '0;
    J        = '0;
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Test 1: table[k] = k%8+1, contiguous.
    for (int k = 0; k < 64; k++) drive_beat(7'((k % 8) + 1), k == 63, 1'b0);
    W = 3'd5; J = 3'd3;
    #1 check_val("cost_5_3", 32'(Cost), 4);
    check_val("t1_lb_const", 32'(LowerBound), 8);
    drive_beat(7'd9, 1'b0, 1'b0); // must be refused while DONE
    clear_pulse();

    // Test 2: all 127 with in_valid toggling every other cycle.
    for (int k = 0; k < 64; k++) begin
      drive_beat(7'd127, k == 63, 1'b0);
      idle(1);
    end
    check_val("t2_lb_const", 32'(LowerBound), 1016);
    drive_beat(7'd1, 1'b1, 1'b0);
    clear_pulse();

    // Test 3: early in_last on beat 40, then clear and random valid reload.
    for (int k = 0; k <= 40; k++) drive_beat(7'(k + 3), k == 40, 1'b0);
    check_val("t3_ready_low", 32'(Ready_tbl), 0);
    clear_pulse();
    for (int k = 0; k < 64; k++) drive_beat(7'($urandom_range(0, 127)), k == 63, 1'b0);
    clear_pulse();

    // Test 4: beat 63 without in_last, then extra beats must be refused.
    for (int k = 0; k < 64; k++) drive_beat(7'((k % 8) + 10), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_beat(7'd55, 1'b1, 1'b0);
    check_val("t4_error_hold", 32'(Error), 1);
    clear_pulse();

    // Test 5: clear on beat 20's handshake drops it; table[20] keeps 14.
    for (int k = 0; k < 20; k++) drive_beat(7'd90, 1'b0, 1'b0);
    drive_beat(7'd99, 1'b0, 1'b1);
    for (int k = 0; k < 64; k++) drive_beat(7'($urandom_range(20, 127)), k == 63, 1'b0);
    clear_pulse();

    // Test 6: asynchronous reset after 30 beats, then a full load.
    for (int k = 0; k < 30; k++) drive_beat(7'(k + 40), 1'b0, 1'b0);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    model_reset();
    sb.delete();
    #1 check_reset_state("midreset");
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 64; k++) drive_beat(7'((63 - k) + 20), k == 63, 1'b0);

    if (sb.size() != 0) check_val("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cost_table_loader.md
Name: cost_table_loader

Overview:
- Upstream feeder for the job-assignment search engine.
- Accepts the 8x8 worker/job cost matrix as a 64-beat valid/ready stream and stores it in a register file.
- Serves the engine's W/J lookups with a combinational Cost read, and computes a row-minimum lower bound on total cost while loading.
- Asserts Ready_tbl when the table is complete and consistent; the engine's reset is held until then.

Parameters:
- N, 8, workers = jobs; the matrix is N x N. Only 8 is supported.
- CW, 7, cost width in bits.
- LBW, 10, lower-bound width in bits. Must hold N*(2^CW-1) = 1016.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a cost beat.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  CW  cost beat. Order is row-major: beat k is Cost(W=k/8, J=k%8).
- in_last  in  1  marks the final beat of the matrix.
- clear  in  1  synchronous restart of loading.
- W  in  3  engine worker index.
- J  in  3  engine job index.
- Cost  out  CW  table[W*8+J], combinational.
- Ready_tbl  out  1  table loaded and consistent.
- LowerBound  out  LBW  sum over rows of the row minimum; valid while Ready_tbl=1.
- Error  out  1  framing error detected.

Behaviour:
- Reset (RST_N=0, async):
  - state=LOAD, idx=0, rowmin=0, lb_acc=0.
  - All 64 table entries = 0.
  - in_ready=1, Ready_tbl=0, Error=0, LowerBound=0.
- Handshake: a beat is accepted when in_valid & in_ready at a rising edge. No combinational path from in_valid to in_ready.
- State LOAD (in_ready=1). On each accepted beat:
  - table[idx] <= in_data; idx <= idx+1 (6-bit).
  - J-field idx[2:0]==0: rowmin <= in_data.
  - Otherwise: rowmin <= min(rowmin, in_data).
  - idx[2:0]==7: lb_acc <= lb_acc + min(rowmin, in_data). Zero-extend operands; no overflow by LBW rule.
- Framing rules, evaluated on each accepted beat:
  - idx==63 and in_last=1: next state DONE.
  - idx==63 and in_last=0: next state ERROR. The beat is still written.
  - idx!=63 and in_last=1: next state ERROR. The beat is still written.
- Wrap-around: idx never wraps in LOAD, because beat 63 always leaves the state.
- State DONE:
  - in_ready=0, Ready_tbl=1.
  - LowerBound=lb_acc, registered and stable.
  - Table frozen.
- State ERROR:
  - in_ready=0, Ready_tbl=0, Error=1.
  - Table holds the partial contents.
- Output timing: Ready_tbl, Error and LowerBound are registered outputs. They rise the cycle after the final or offending beat is accepted.
- clear=1 at a rising edge, from any state:
  - state=LOAD, idx=0, lb_acc=0, rowmin=0, Error=0, Ready_tbl=0.
  - Table contents retained until overwritten.
  - clear beats a simultaneous accepted beat: that beat is dropped, not written, idx stays 0.
- Cost read:
  - Pure combinational mux of table[{W,J}], available in every state.
  - Contents are only guaranteed meaningful while Ready_tbl=1.
  - A read of an entry written on the same edge returns the new value after that edge.
- Reset mid-load: all state and table entries return to reset values immediately. There is no partial recovery.
- in_valid=0 gaps of any length are allowed. idx and accumulators hold.
- The block never deasserts Ready_tbl except on clear or reset.

Test Plan:
- Load table[k]=k%8+1 contiguously, in_last on beat 63:
  - Ready_tbl=1 one cycle after beat 63.
  - Each row min is 1, so LowerBound=8.
  - Error=0 and in_ready=0.
  - W=5,J=3 gives Cost=4.
- Load table[k]=127 for all k, with in_valid toggling every other cycle:
  - LowerBound=1016 and Ready_tbl=1.
  - Exactly 64 beats accepted; idx holds during gaps.
- Assert in_last on beat 40:
  - Error=1 and in_ready=0 the next cycle; Ready_tbl stays 0.
  - Then pulse clear and reload a valid matrix: Error=0, Ready_tbl=1, correct LowerBound.
- Beat 63 with in_last=0:
  - Error=1 and Ready_tbl=0.
  - Further in_valid beats are not accepted (in_ready=0).
- Assert clear in the same cycle as beat 20's handshake:
  - The beat is dropped and idx=0.
  - A full 64-beat reload yields row mins and LowerBound computed only from the new data.
- Drop RST_N asynchronously mid-load (after 30 beats):
  - in_ready=1, Ready_tbl=0 and Cost=0 for all W/J immediately.
  - A subsequent full load succeeds.
